// File: rtl/alu_pkg.sv
// Shared ALU definitions: comparator FSM states and the signedness mode encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_BUSY = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/comparator.sv
// Combinational SIZE-bit unsigned magnitude comparator; less-than is implied by !gt && !eq.
module comparator #(
    parameter int SIZE = 1
) (
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    output logic            o_gt,
    output logic            o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, unsigned or signed.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module seq_comparator
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_a_greater,
    output logic             equal,
    output logic             is_a_less,
    output logic [1:0]       dbg_state
);

    localparam int NUM_STEPS = WIDTH / CHUNK;
    localparam int STEP_W    = $clog2(NUM_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [WIDTH-1:0]  SIGN_BIT  = WIDTH'(1) << (WIDTH - 1);

    cmp_state_t        r_state;
    cmp_state_t        w_next_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  w_bias;
    logic [STEP_W-1:0] r_step;
    logic              r_decided;
    logic              r_gt;
    logic              r_lt;
    logic              r_res_gt;
    logic              r_res_eq;
    logic              r_res_lt;
    logic              w_slice_gt;
    logic              w_slice_eq;
    logic              w_last;
    logic              w_fin_gt;
    logic              w_fin_eq;
    logic              w_fin_lt;

    comparator #(.SIZE(CHUNK)) u_slice_cmp (
        .i_a  (r_a_sh[WIDTH-1 -: CHUNK]),
        .i_b  (r_b_sh[WIDTH-1 -: CHUNK]),
        .o_gt (w_slice_gt),
        .o_eq (w_slice_eq)
    );

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_bias = (is_signed == CMP_SIGNED) ? SIGN_BIT : '0;
    assign w_last = (r_step == LAST_STEP);

    // Final verdict as seen on the last BUSY cycle, including that cycle's slice.
    assign w_fin_gt = r_decided ? r_gt : w_slice_gt;
    assign w_fin_lt = r_decided ? r_lt : (!w_slice_gt && !w_slice_eq);
    assign w_fin_eq = !r_decided && w_slice_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CMP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CMP_IDLE: if (in_valid)  w_next_state = CMP_BUSY;
            CMP_BUSY: if (w_last)    w_next_state = CMP_DONE;
            CMP_DONE: if (out_ready) w_next_state = CMP_IDLE;
            default:                 w_next_state = CMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_step    <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_res_gt  <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_lt  <= 1'b0;
        end else begin
            case (r_state)
                CMP_IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= a ^ w_bias;
                        r_b_sh    <= b ^ w_bias;
                        r_step    <= '0;
                        r_decided <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                    end
                end
                CMP_BUSY: begin
                    if (!r_decided && !w_slice_eq) begin
                        r_decided <= 1'b1;
                        r_gt      <= w_slice_gt;
                        r_lt      <= !w_slice_gt;
                    end
                    r_a_sh <= r_a_sh << CHUNK;
                    r_b_sh <= r_b_sh << CHUNK;
                    r_step <= r_step + STEP_W'(1);
                    if (w_last) begin
                        r_res_gt <= w_fin_gt;
                        r_res_eq <= w_fin_eq;
                        r_res_lt <= w_fin_lt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == CMP_IDLE);
    assign out_valid    = (r_state == CMP_DONE);
    assign is_a_greater = r_res_gt;
    assign equal        = r_res_eq;
    assign is_a_less    = r_res_lt;
    assign dbg_state    = r_state;

endmodule
